// File: rtl/mux_stream_arb_pkg.sv
// Shared types and helpers for the stream mux/arbiter.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
// Contents: mux_mode_t (select vs round-robin), stage_t (output register state),
//           next_idx() cyclic index increment.
package mux_pkg;

  typedef enum logic {MODE_SEL, MODE_RR} mux_mode_t;

  typedef enum logic {ST_EMPTY, ST_FULL} stage_t;

  // Cyclic increment over 0..n-1; any index at or past the last wraps to 0.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mux_stream_arb_if.sv
// Bundle of the N-input / 1-output stream handshakes of mux_stream_arb.
// Latency: n/a (wiring only).
// Backpressure: in_ready per channel, out_ready from the consumer.
// Ports: mode/sel steer the grant; in_valid/in_data/in_ready per channel;
//        out_valid/out_data/out_ch/out_ready towards the consumer.
interface mux_stream_arb_if #(
  parameter int N_CH      = 4,
  parameter int WIDTH_BUS = 8
);
  import mux_pkg::*;

  localparam int WIDTH_SEL = $clog2(N_CH);

  mux_mode_t                          mode;
  logic [WIDTH_SEL-1:0]               sel;
  logic [N_CH-1:0]                    in_valid;
  logic [N_CH-1:0][WIDTH_BUS-1:0]     in_data;
  logic [N_CH-1:0]                    in_ready;
  logic                               out_valid;
  logic [WIDTH_BUS-1:0]               out_data;
  logic [WIDTH_SEL-1:0]               out_ch;
  logic                               out_ready;

  // slave: the mux itself; master: producers plus consumer around it.
  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

endinterface

// File: rtl/mux_stream_arb_rr_pick.sv
// Cyclic priority finder: first set req bit searching upward from ptr+1, wrapping.
// Latency: combinational.
// Backpressure: none; the caller qualifies the grant.
// Ports: req (one bit per channel), ptr (last granted index) -> gnt_valid, gnt_idx.
module rr_pick
  import mux_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0]          req,
  input  logic [$clog2(N_CH)-1:0]  ptr,
  output logic                     gnt_valid,
  output logic [$clog2(N_CH)-1:0]  gnt_idx
);

  localparam int WIDTH_SEL = $clog2(N_CH);

  always_comb begin
    int  idx;
    logic hit;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = next_idx(int'(ptr), N_CH);
    for (int k = 0; k < N_CH; k++) begin
      // Constant-index lookup keeps the selection in range for non-power-of-two N_CH.
      hit = 1'b0;
      for (int j = 0; j < N_CH; j++) begin
        if (j == idx) hit = req[j];
      end
      if (!gnt_valid && hit) begin
        gnt_valid = 1'b1;
        gnt_idx   = WIDTH_SEL'(idx);
      end
      idx = next_idx(idx, N_CH);
    end
  end

endmodule

// File: rtl/mux_stream_arb.sv
// N-channel stream mux with explicit-select or round-robin grant into one output register.
// Latency: 1 cycle from input handshake to out_valid.
// Backpressure: all in_ready drop while the output register is full and out_ready=0.
// Ports: clk, rst (async, active-high), bus (slave modport of mux_stream_arb_if).
module mux_stream_arb
  import mux_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int WIDTH_BUS = 8
) (
  input  logic              clk,
  input  logic              rst,
  mux_stream_arb_if.slave   bus
);

  localparam int WIDTH_SEL = $clog2(N_CH);

  stage_t                state;
  logic [WIDTH_SEL-1:0]  ptr;
  logic [WIDTH_BUS-1:0]  data_q;
  logic [WIDTH_SEL-1:0]  ch_q;

  logic                  rr_valid;
  logic [WIDTH_SEL-1:0]  rr_idx;
  logic                  gnt_valid;
  logic [WIDTH_SEL-1:0]  gnt_idx;
  logic [WIDTH_BUS-1:0]  gnt_data;
  logic                  load_en;
  logic                  xfer;

  rr_pick #(.N_CH(N_CH)) u_pick (
    .req       (bus.in_valid),
    .ptr       (ptr),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  // Mode 0 compares sel against every legal index, so an out-of-range sel
  // simply matches nothing instead of falling back to channel 0.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (bus.mode == MODE_RR) begin
      gnt_valid = rr_valid;
      gnt_idx   = rr_idx;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (bus.sel == WIDTH_SEL'(i) && bus.in_valid[i]) begin
          gnt_valid = 1'b1;
          gnt_idx   = WIDTH_SEL'(i);
        end
      end
    end
  end

  assign load_en = (state == ST_EMPTY) || bus.out_ready;
  assign xfer    = load_en && gnt_valid;

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      bus.in_ready[i] = xfer && (gnt_idx == WIDTH_SEL'(i));
      if (gnt_idx == WIDTH_SEL'(i)) gnt_data = bus.in_data[i];
    end
  end

  // ptr resets to the last channel so the first round-robin search starts at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_EMPTY;
      data_q <= '0;
      ch_q   <= '0;
      ptr    <= WIDTH_SEL'(N_CH - 1);
    end else if (xfer) begin
      state  <= ST_FULL;
      data_q <= gnt_data;
      ch_q   <= gnt_idx;
      if (bus.mode == MODE_RR) ptr <= gnt_idx;
    end else if (bus.out_ready) begin
      // Drained with nothing new: data/channel keep their last values.
      state <= ST_EMPTY;
    end
  end

  assign bus.out_valid = (state == ST_FULL);
  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;

endmodule

// File: tb/tb_mux_stream_arb.sv
module tb_mux_stream_arb;
  import mux_pkg::*;

  localparam int NA = 4;
  localparam int NB = 3;

  logic clk;
  logic rst;

  mux_stream_arb_if #(.N_CH(NA), .WIDTH_BUS(8)) a ();
  mux_stream_arb_if #(.N_CH(NB), .WIDTH_BUS(8)) b ();

  mux_stream_arb #(.N_CH(NA), .WIDTH_BUS(8)) u_a (.clk(clk), .rst(rst), .bus(a));
  mux_stream_arb #(.N_CH(NB), .WIDTH_BUS(8)) u_b (.clk(clk), .rst(rst), .bus(b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int ncheck = 0;
  int nerr   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncheck++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model for DUT a: decides each cycle which channel the rules grant,
  // and queues the beat that should subsequently appear on the output.
  typedef struct {
    logic [7:0] d;
    int         ch;
  } beat_t;

  beat_t q[$];
  int    m_ptr;
  bit    m_full;

  always begin : model
    int         g;
    int         c;
    bit         load;
    logic [3:0] exp_rdy;
    beat_t      bt;
    @(negedge clk);
    if (rst) begin
      m_ptr  = NA - 1;
      m_full = 1'b0;
      q.delete();
    end else begin
      g = -1;
      if (a.mode == MODE_SEL) begin
        if (int'(a.sel) < NA && a.in_valid[a.sel]) g = int'(a.sel);
      end else begin
        for (int k = 1; k <= NA; k++) begin
          c = (m_ptr + k) % NA;
          if (g < 0 && a.in_valid[c]) g = c;
        end
      end
      load    = !m_full || a.out_ready;
      exp_rdy = '0;
      if (load && g >= 0) exp_rdy[g] = 1'b1;
      chk("in_ready", a.in_ready, exp_rdy);
      if (load && g >= 0) begin
        bt.d   = a.in_data[g];
        bt.ch  = g;
        m_full = 1'b1;
        if (a.mode == MODE_RR) m_ptr = g;
        #2 q.push_back(bt);
      end else if (a.out_ready) begin
        m_full = 1'b0;
      end
    end
  end

  // Monitor: the register content must be the oldest expected beat.
  always begin : monitor
    @(negedge clk);
    if (!rst) begin
      chk("out_valid", a.out_valid, q.size() != 0);
      if (a.out_valid && q.size() > 0) begin
        chk("out_data", a.out_data, q[0].d);
        chk("out_ch", a.out_ch, q[0].ch);
        if (a.out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    rst         = 1'b1;
    a.mode      = MODE_SEL;
    a.sel       = '0;
    a.in_valid  = '0;
    a.in_data   = '0;
    a.out_ready = 1'b0;
    b.mode      = MODE_SEL;
    b.sel       = '0;
    b.in_valid  = '0;
    b.in_data   = '0;
    b.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset then idle
    repeat (2) tick();
    chk("rst_out_valid", a.out_valid, 1'b0);
    chk("rst_out_data", a.out_data, 8'h00);
    chk("rst_out_ch", a.out_ch, 0);
    chk("rst_in_ready", a.in_ready, 4'b0000);
    chk("rst_b_out_valid", b.out_valid, 1'b0);

    // Out-of-range select on the 3-channel instance
    b.mode        = MODE_SEL;
    b.sel         = 2'd3;
    b.in_valid    = 3'b111;
    b.in_data[0]  = 8'h30;
    b.in_data[1]  = 8'h31;
    b.in_data[2]  = 8'h32;
    b.out_ready   = 1'b1;
    #1 chk("b_oor_in_ready", b.in_ready, 3'b000);
    tick();
    chk("b_oor_out_valid", b.out_valid, 1'b0);
    tick();
    chk("b_oor_out_valid2", b.out_valid, 1'b0);
    b.sel = 2'd2;
    #1 chk("b_sel2_in_ready", b.in_ready, 3'b100);
    tick();
    chk("b_sel2_out_ch", b.out_ch, 2);
    chk("b_sel2_out_data", b.out_data, 8'h32);
    b.in_valid = '0;

    // Mode 0, explicit select of channel 2
    a.out_ready   = 1'b1;
    a.sel         = 2'd2;
    a.in_data[2]  = 8'hA5;
    a.in_valid    = 4'b0100;
    #1 chk("m0_in_ready", a.in_ready, 4'b0100);
    tick();
    chk("m0_out_valid", a.out_valid, 1'b1);
    chk("m0_out_data", a.out_data, 8'hA5);
    chk("m0_out_ch", a.out_ch, 2);
    a.sel = 2'd3;
    tick();
    chk("m0_sel3_out_valid", a.out_valid, 1'b0);

    // Mode 1, all channels valid: strict rotation starting at channel 0
    a.mode = MODE_RR;
    for (int i = 0; i < NA; i++) a.in_data[i] = 8'(10 + i);
    a.in_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_out_ch", a.out_ch, i % NA);
      chk("rr_out_data", a.out_data, 10 + (i % NA));
    end
    a.in_valid = '0;
    tick();
    chk("drain_out_valid", a.out_valid, 1'b0);

    // Backpressure with channel 1 held
    a.out_ready = 1'b0;
    a.in_valid  = 4'b0010;
    tick();
    chk("bp_load_ch", a.out_ch, 1);
    a.in_valid = 4'hF;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", a.in_ready, 4'b0000);
      tick();
      chk("bp_hold_ch", a.out_ch, 1);
      chk("bp_hold_data", a.out_data, 11);
      chk("bp_hold_valid", a.out_valid, 1'b1);
    end
    a.out_ready = 1'b1;
    #1 chk("bp_release_in_ready", a.in_ready, 4'b0100);
    tick();
    chk("bp_release_ch", a.out_ch, 2);
    chk("bp_release_data", a.out_data, 12);

    // Randomized traffic, checked by the model and monitor
    for (int n = 0; n < 600; n++) begin
      @(posedge clk);
      #1;
      a.mode      = mux_mode_t'($urandom_range(0, 1));
      a.sel       = 2'($urandom_range(0, NA - 1));
      a.in_valid  = 4'($urandom);
      a.out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NA; i++) a.in_data[i] = 8'($urandom);
    end

    // Asynchronous reset while full and stalled
    @(posedge clk);
    #1;
    a.mode      = MODE_RR;
    a.in_valid  = 4'b0100;
    a.out_ready = 1'b0;
    tick();
    chk("ar_full_before", a.out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", a.out_valid, 1'b0);
    chk("ar_out_data", a.out_data, 8'h00);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    a.in_valid  = 4'hF;
    a.out_ready = 1'b1;
    tick();
    chk("ar_first_rr_ch", a.out_ch, 0);
    a.in_valid = '0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", ncheck, nerr);
    $finish;
  end

endmodule
